// File: rtl/camera_pixel_capture_if.sv
// camera_pixel_capture_if: camera byte stream in, FIFO write words and sticky status out.
interface camera_pixel_capture_if;
  logic cam_vsync;
  logic cam_href;
  logic [7:0] cam_data;
  logic fifo_full;
  logic wr_en;
  logic [16:0] dout;
  logic overflow;
  logic frame_err;
  logic [7:0] frame_cnt;
  modport master (
    output cam_vsync, cam_href, cam_data, fifo_full,
    input wr_en, dout, overflow, frame_err, frame_cnt
  );
  modport slave (
    input cam_vsync, cam_href, cam_data, fifo_full,
    output wr_en, dout, overflow, frame_err, frame_cnt
  );
endinterface

// File: rtl/camera_pixel_capture.sv
// camera_pixel_capture: packs RGB565 byte pairs into fixed-size frames of 17-bit FIFO words.
module camera_pixel_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input logic clk,
  input logic rst_n,
  camera_pixel_capture_if.slave bus
);
  localparam logic [9:0] H_END = 10'(H_ACTIVE);
  localparam logic [8:0] V_END = 9'(V_ACTIVE);
  localparam logic [18:0] PIX_END = 19'(H_ACTIVE * V_ACTIVE);
  typedef enum logic [2:0] {SYNC, LINE, LO, HI, PAD, DONE} state_t;
  state_t state;
  logic vsync_q;
  logic href_q;
  logic pad_frame;
  logic [7:0] hi;
  logic [9:0] x_cnt;
  logic [8:0] y_cnt;
  logic [18:0] pix_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SYNC;
      vsync_q <= 1'b0;
      href_q <= 1'b0;
      pad_frame <= 1'b0;
      hi <= '0;
      x_cnt <= '0;
      y_cnt <= '0;
      pix_cnt <= '0;
      bus.wr_en <= 1'b0;
      bus.dout <= '0;
      bus.overflow <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.frame_cnt <= '0;
    end else begin
      vsync_q <= bus.cam_vsync;
      href_q <= bus.cam_href;
      bus.wr_en <= 1'b0;
      case (state)
        SYNC:
          if (vsync_q && !bus.cam_vsync) begin
            state <= LINE;
            x_cnt <= '0;
            y_cnt <= '0;
            pix_cnt <= '0;
            pad_frame <= 1'b0;
          end
        LINE:
          if (bus.cam_vsync && y_cnt < V_END) begin
            state <= PAD;
            pad_frame <= 1'b1;
          end else if (bus.cam_href) begin
            hi <= bus.cam_data;
            x_cnt <= '0;
            state <= LO;
          end
        LO, HI:
          // href low ends the line; an orphan high byte left in LO is simply dropped
          if (!bus.cam_href) begin
            if (x_cnt < H_END) state <= PAD;
            else begin
              y_cnt <= y_cnt + 9'd1;
              state <= LINE;
            end
          end else if (state == HI) begin
            hi <= bus.cam_data;
            state <= LO;
          end else if (x_cnt >= H_END) state <= HI;
          else if (bus.fifo_full) begin
            bus.overflow <= 1'b1;
            x_cnt <= '0;
            y_cnt <= '0;
            pix_cnt <= '0;
            state <= SYNC;
          end else begin
            bus.wr_en <= 1'b1;
            bus.dout <= {pix_cnt == 19'd0, hi, bus.cam_data};
            pix_cnt <= pix_cnt + 19'd1;
            x_cnt <= x_cnt + 10'd1;
            if (pix_cnt + 19'd1 == PIX_END) begin
              bus.frame_cnt <= bus.frame_cnt + 8'd1;
              state <= DONE;
            end else state <= HI;
          end
        PAD:
          if (bus.cam_href && !href_q) begin
            bus.frame_err <= 1'b1;
            state <= SYNC;
          end else if (!bus.fifo_full) begin
            bus.wr_en <= 1'b1;
            bus.dout <= '0;
            pix_cnt <= pix_cnt + 19'd1;
            x_cnt <= x_cnt + 10'd1;
            if (pix_cnt + 19'd1 == PIX_END) begin
              bus.frame_cnt <= bus.frame_cnt + 8'd1;
              state <= DONE;
            end else if (!pad_frame && x_cnt + 10'd1 == H_END) begin
              y_cnt <= y_cnt + 9'd1;
              state <= LINE;
            end
          end
        DONE:
          if (bus.cam_vsync) state <= SYNC;
        default: state <= SYNC;
      endcase
    end
  end
endmodule
